// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF input synchroniser, mid-bit sampling FSM and a small
// receive FIFO drained through a valid/ready handshake, with framing/overrun pulses.
module uart_rx #(
    parameter int ClockFrequency = 50_000_000,
    parameter int BaudRate       = 115_200,
    parameter int FifoDepth      = 4
) (
    input  logic                         clk_sys_i,
    input  logic                         rst_sys_i,
    input  logic                         uart_rx_i,
    output logic [7:0]                   rx_data_o,
    output logic                         rx_valid_o,
    input  logic                         rx_ready_i,
    output logic [$clog2(FifoDepth):0]   rx_level_o,
    output logic                         frame_err_o,
    output logic                         overrun_o
);

    localparam int ClocksPerBit = ClockFrequency / BaudRate;
    localparam int CntW         = $clog2(ClocksPerBit);
    localparam int AddrW        = $clog2(FifoDepth);

    localparam logic [CntW-1:0] CntLast = CntW'(ClocksPerBit - 1);
    localparam logic [CntW-1:0] CntHalf = CntW'(ClocksPerBit / 2 - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } state_e;

    // Handshake: a byte leaves the FIFO on a clock edge where rx_valid_o && rx_ready_i;
    // rx_data_o holds steady while rx_valid_o && !rx_ready_i.

    logic [1:0]      sync_q;
    logic            rx_s;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      sh_q, sh_d;
    logic            push;
    logic            frame_err_q, frame_err_d;
    logic            overrun_q, overrun_d;

    logic [7:0]      mem_q [FifoDepth];
    logic [AddrW:0]  wr_ptr_q, rd_ptr_q;
    logic            fifo_full, fifo_empty, pop, wr_en;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], uart_rx_i};
        end
    end

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            sh_q        <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sh_q        <= sh_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        sh_d        = sh_q;
        push        = 1'b0;
        frame_err_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (cnt_q == CntHalf) begin
                    cnt_d = '0;
                    idx_d = '0;
                    // A line back high at mid start bit is treated as noise.
                    state_d = rx_s ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StData: begin
                if (cnt_q == CntLast) begin
                    cnt_d       = '0;
                    sh_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StStop: begin
                if (cnt_q == CntLast) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        push    = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBreak: begin
                // Hold here so a stuck-low line reports a single framing error.
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AddrW{1'b0}}});
    assign pop        = !fifo_empty && rx_ready_i;
    // When full, a simultaneous pop frees the head slot that the write lands in.
    assign wr_en      = push && (!fifo_full || pop);
    assign overrun_d  = push && fifo_full && !pop;

    always_ff @(posedge clk_sys_i) begin
        if (rst_sys_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < FifoDepth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q[AddrW-1:0]] <= sh_q;
                wr_ptr_q                   <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    assign rx_data_o   = mem_q[rd_ptr_q[AddrW-1:0]];
    assign rx_valid_o  = !fifo_empty;
    assign rx_level_o  = wr_ptr_q - rd_ptr_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver for the Ibex demo system: the receive-side counterpart of the system's existing UART transmitter, deserialising 8N1 frames from the board's RX pin. The block sits behind the bus-facing UART register interface and exposes received bytes through a small FIFO with a valid/ready handshake. It also flags framing errors and overruns.

## Interface
- ClockFrequency, 50_000_000: `clk_sys_i` frequency in Hz.
- BaudRate, 115_200: line rate in bit/s. ClocksPerBit = ClockFrequency / BaudRate, integer floor, which must be ≥ 4.
- FifoDepth, 4: receive FIFO entries, a power of two ≥ 2.
- clk_sys_i  in  1  system clock; the only clock.
- rst_sys_i  in  1  synchronous, active-high reset.
- uart_rx_i  in  1  asynchronous serial input; idles high.
- rx_data_o  out  8  byte at the FIFO head.
- rx_valid_o  out  1  FIFO non-empty.
- rx_ready_i  in  1  consumer accepts the head byte when rx_valid_o && rx_ready_i.
- rx_level_o  out  $clog2(FifoDepth)+1  FIFO occupancy.
- frame_err_o  out  1  one-cycle pulse when a frame has a bad stop bit.
- overrun_o  out  1  one-cycle pulse when a complete byte is dropped because the FIFO is full.

## Operation
- **Input synchronisation:** `uart_rx_i` passes through a 2-FF synchroniser; its reset value is 1. All logic uses the synchronised signal `rx_s`.
- **Counters:** bit-timer `cnt` counts 0..ClocksPerBit-1. Bit index `idx` runs 0..7. Shift register `sh` is 8 bits wide and fills LSB first.
- **States:**
  - IDLE: when `rx_s` == 0, go to START with cnt = 0.
  - START: when cnt reaches ClocksPerBit/2 - 1 (mid start bit), sample `rx_s`.
    - If 1: glitch; return to IDLE, nothing recorded.
    - If 0: go to DATA with cnt = 0 and idx = 0.
  - DATA: when cnt reaches ClocksPerBit - 1, shift `rx_s` into `sh[idx]` and reset cnt. After idx == 7, go to STOP.
  - STOP: when cnt reaches ClocksPerBit - 1, sample the stop bit.
    - If 1: push `sh` into the FIFO and go to IDLE.
    - If 0: pulse frame_err_o, discard the byte, and go to BREAK.
  - BREAK: wait for `rx_s` == 1, then go to IDLE. A held-low line therefore reports exactly one framing error.
- **FIFO:** synchronous, FifoDepth entries, with read/write pointers one bit wider than the address.
  - rx_data_o is the head entry. It is don't-care while empty and must not change while rx_valid_o && !rx_ready_i.
  - A pop occurs only when rx_valid_o && rx_ready_i.
  - A push into a full FIFO with no simultaneous pop drops the new byte, pulses overrun_o, and leaves the contents unchanged.
  - A push and a pop in the same cycle are both performed; the level is unchanged and there is no overrun, even when full.
  - A push and a pop in the same cycle while empty is impossible, because rx_valid_o is 0.
- **Reset values:** state IDLE; cnt = 0, idx = 0, sh = 0; FIFO empty; rx_valid_o = 0; rx_level_o = 0; rx_data_o = 0; frame_err_o = 0; overrun_o = 0.
- **Reset mid-frame:** the partial frame is discarded. After reset the receiver waits in IDLE for the next falling edge; a frame already in progress may produce a spurious start, which is resolved by glitch rejection or a framing error.

## Timing
- Synchroniser latency: 2 cycles from a pin edge to `rx_s`.
- Sample points are measured from the first cycle `rx_s` == 0:
  - start bit at ClocksPerBit/2 cycles;
  - data bit k at ClocksPerBit/2 + (k+1)·ClocksPerBit cycles;
  - stop bit at ClocksPerBit/2 + 9·ClocksPerBit cycles.
- **Push latency:** the FIFO write happens on the clock edge ending the stop-sample cycle. If the FIFO was empty, rx_valid_o, rx_data_o and rx_level_o update 1 cycle after the stop sample.
- **Error pulses:** frame_err_o and overrun_o are registered and assert 1 cycle after the stop-sample cycle, for exactly 1 cycle.
- **Back-to-back frames:** a start bit immediately following a valid stop bit is detected. IDLE is re-entered at the stop-bit midpoint, leaving half a bit of margin.
- **Pop:** takes effect at the clock edge. The next head entry, or rx_valid_o = 0, is visible the following cycle.
- **Throughput:** one byte per cycle on the consumer side.

## Test plan
All scenarios use ClockFrequency = 1_600_000 and BaudRate = 100_000 (ClocksPerBit = 16), FifoDepth = 4.
- **Single byte:** drive 0x5A as an 8N1 frame, rx_ready_i = 0.
  - rx_valid_o = 1, rx_data_o = 0x5A, rx_level_o = 1, 1 cycle after the stop sample (153 cycles after `rx_s` falls).
  - Then rx_ready_i = 1 for 1 cycle → rx_valid_o = 0, rx_level_o = 0.
- **Glitch rejection:** a 4-cycle low pulse on uart_rx_i → state returns to IDLE, no push, no frame_err_o.
- **Framing error:** frame 0xA5 with the stop bit low and the line held low for 40 more cycles → one frame_err_o pulse, FIFO empty. Then line high followed by frame 0x3C → 0x3C received.
- **Overrun:** 5 back-to-back frames 0x01..0x05 with rx_ready_i = 0.
  - rx_level_o = 4; overrun_o pulses once on the 5th frame.
  - Draining yields 0x01, 0x02, 0x03, 0x04.
- **Full FIFO with simultaneous push and pop:** FIFO full with 0x11..0x14; rx_ready_i = 1 in exactly the push cycle of 0x15 → no overrun, level stays 4; draining yields 0x12, 0x13, 0x14, 0x15.
- **Reset mid-frame:** assert rst_sys_i for 1 cycle during DATA bit 3.
  - Immediately after: all outputs at reset values.
  - Line then idle high for 20 cycles, then frame 0xC3 → 0xC3 received, no errors.
